// File: rtl/mux_pkg.sv
// Shared constants, FSM state type and width helper for the N:1 registered mux.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ARB = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index width that stays at least one bit even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Bundle of input channels, select controls and the output handshake of mux_nx1_rr.
interface mux_nx1_rr_if #(
  parameter int CH    = 4,
  parameter int WIDTH = 8
);
  import mux_pkg::*;

  localparam int CH_W = clog2_min1(CH);

  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic                sel_mode;
  logic [CH_W-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic [CH_W-1:0]     out_ch;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, sel_mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, sel_mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational channel picker: round-robin after ptr when MUX_RR_EN is defined,
// otherwise a lowest-index-first priority encoder (ptr ignored).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CH   = 4,
  localparam int CH_W = clog2_min1(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH-1:0]   gnt,
  output logic [CH_W-1:0] gnt_idx
);

`ifdef MUX_RR_EN
  always_comb begin
    int  c;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    // ptr <= CH-1, so a single subtraction keeps the index inside 0..CH-1.
    for (int i = 1; i <= CH; i++) begin
      c = int'(ptr) + i;
      if (c >= CH) c = c - CH;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = CH_W'(c);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = CH_W'(c);
      end
    end
  end
`endif

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel registered mux with valid/ready on every side; external select or arbitration.
// Build option MUX_RR_EN: defined = round-robin arbitration, undefined = fixed priority.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int CH    = 4,
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  mux_nx1_rr_if.slave bus
);

  localparam int CH_W = clog2_min1(CH);

  state_t            state, state_nxt;
  logic              load_en, xfer;
  logic [CH-1:0]     arb_gnt, grant;
  logic [CH_W-1:0]   arb_idx, grant_idx, ptr_arb;
  logic [WIDTH-1:0]  grant_data, data_p1;
  logic [CH_W-1:0]   ch_p1;

`ifdef MUX_RR_EN
  logic [CH_W-1:0] ptr;

  // Reset to CH-1 so the first arbitration search begins at channel 0.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= CH_W'(CH - 1);
    else if (xfer) ptr <= grant_idx;
  end
  assign ptr_arb = ptr;
`else
  assign ptr_arb = '0;
`endif

  rr_arbiter #(.CH(CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_arb),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (bus.sel_mode == MODE_ARB) begin
      grant     = arb_gnt;
      grant_idx = arb_idx;
    end else begin
      // Loop bound keeps an out-of-range sel from ever indexing past CH-1.
      for (int k = 0; k < CH; k++) begin
        if (CH_W'(k) == bus.sel && bus.in_valid[k]) begin
          grant[k]  = 1'b1;
          grant_idx = CH_W'(k);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CH; k++)
      if (grant[k]) grant_data = bus.in_data[k*WIDTH +: WIDTH];
  end

  assign load_en      = (state == EMPTY) || bus.out_ready;
  assign bus.in_ready = (load_en && !rst) ? grant : '0;
  assign xfer         = load_en && (|grant) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (xfer)                                 state_nxt = FULL;
    else if (state == FULL && bus.out_ready) state_nxt = EMPTY;
  end

  always_comb begin
    bus.out_valid = (state == FULL);
  end

  // p1: single output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (xfer) begin
      data_p1 <= grant_data;
      ch_p1   <= grant_idx;
    end
  end

  assign bus.out_data = data_p1;
  assign bus.out_ch   = ch_p1;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Randomized and directed bench for mux_nx1_rr (CH=4 and CH=3) against a behavioural model.
module tb_mux_nx1_rr;
  import mux_pkg::*;

`ifdef MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_nx1_rr_if #(.CH(4), .WIDTH(8)) bus4();
  mux_nx1_rr_if #(.CH(3), .WIDTH(8)) bus3();

  mux_nx1_rr #(.CH(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  mux_nx1_rr #(.CH(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: one held beat per instance plus the last granted channel.
  typedef struct {
    bit full;
    int data;
    int ch;
    int last;
  } mdl_t;
  mdl_t m[2];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic fetch(input int d, output logic [3:0] v, output logic mode,
                       output int sel, output logic ordy, output logic [31:0] dat);
    if (d == 0) begin
      v = bus4.in_valid; mode = bus4.sel_mode; sel = int'(bus4.sel);
      ordy = bus4.out_ready; dat = bus4.in_data;
    end else begin
      v = {1'b0, bus3.in_valid}; mode = bus3.sel_mode; sel = int'(bus3.sel);
      ordy = bus3.out_ready; dat = {8'h00, bus3.in_data};
    end
  endtask

  function automatic int exp_grant(input int n, input logic [3:0] v, input logic mode,
                                   input int sel, input int last);
    if (mode == MODE_SEL) return (sel < n && v[sel]) ? sel : -1;
    if (RR) begin
      for (int i = 1; i <= n; i++) if (v[(last + i) % n]) return (last + i) % n;
    end else begin
      for (int c = 0; c < n; c++) if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d].full = 0; m[d].data = 0; m[d].ch = 0; m[d].last = nch(d) - 1;
    end
  endtask

  task automatic model_ready(input int d, output logic [31:0] rdy);
    logic [3:0] v; logic mode, ordy; int sel, g; logic [31:0] dat;
    fetch(d, v, mode, sel, ordy, dat);
    g = exp_grant(nch(d), v, mode, sel, m[d].last);
    rdy = (!rst && (!m[d].full || ordy) && g >= 0) ? (32'd1 << g) : 32'd0;
  endtask

  task automatic model_edge(input int d);
    logic [3:0] v; logic mode, ordy; int sel, g; logic [31:0] dat;
    fetch(d, v, mode, sel, ordy, dat);
    g = exp_grant(nch(d), v, mode, sel, m[d].last);
    if (rst) begin
      m[d].full = 0; m[d].data = 0; m[d].ch = 0; m[d].last = nch(d) - 1;
    end else if ((!m[d].full || ordy) && g >= 0) begin
      m[d].full = 1; m[d].data = int'((dat >> (g * 8)) & 32'hFF);
      m[d].ch = g; m[d].last = g;
    end else if (m[d].full && ordy) begin
      m[d].full = 0;
    end
  endtask

  // One clock: check readies on current inputs, advance model, check registered outputs.
  task automatic step();
    logic [31:0] r0, r1;
    #1;
    model_ready(0, r0);
    model_ready(1, r1);
    chk("in_ready4", 32'(bus4.in_ready), r0);
    chk("in_ready3", 32'(bus3.in_ready), r1);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("out_valid4", 32'(bus4.out_valid), 32'(m[0].full));
    chk("out_data4",  32'(bus4.out_data),  32'(m[0].data));
    chk("out_ch4",    32'(bus4.out_ch),    32'(m[0].ch));
    chk("out_valid3", 32'(bus3.out_valid), 32'(m[1].full));
    chk("out_data3",  32'(bus3.out_data),  32'(m[1].data));
    chk("out_ch3",    32'(bus3.out_ch),    32'(m[1].ch));
  endtask

  initial begin
    model_reset();
    bus4.in_data = 32'h44332211; bus4.in_valid = 4'hF; bus4.sel_mode = MODE_ARB;
    bus4.sel = 2'd0; bus4.out_ready = 1'b1;
    bus3.in_data = 24'h332211; bus3.in_valid = 3'h7; bus3.sel_mode = MODE_ARB;
    bus3.sel = 2'd0; bus3.out_ready = 1'b1;

    // Reset held two cycles with every channel valid
    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(bus4.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus4.out_data), 32'd0);
    chk("rst_out_ch", 32'(bus4.out_ch), 32'd0);
    rst = 1'b0;
    step();
    chk("first_grant", 32'(bus4.out_ch), 32'd0);
    chk("first_data", 32'(bus4.out_data), 32'h11);

    // External select
    bus3.in_valid = 3'h0;
    bus4.sel_mode = MODE_SEL; bus4.sel = 2'd2; bus4.in_data = 32'h00A50000;
    #1 chk("ext_ready", 32'(bus4.in_ready), 32'h4);
    step();
    chk("ext_data", 32'(bus4.out_data), 32'hA5);
    chk("ext_ch", 32'(bus4.out_ch), 32'd2);
    bus4.in_valid = 4'b1011;
    #1 chk("ext_novalid_ready", 32'(bus4.in_ready), 32'd0);
    step();
    chk("ext_drop_valid", 32'(bus4.out_valid), 32'd0);

    // Arbitration sequence from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus4.sel_mode = MODE_ARB; bus4.in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus4.in_data = $urandom;
      step();
      chk("arb_all", 32'(bus4.out_ch), RR ? 32'(i % 4) : 32'd0);
    end
    bus4.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arb_odd", 32'(bus4.out_ch), (RR && (i % 2 == 1)) ? 32'd3 : 32'd1);
    end

    // Backpressure
    bus4.sel_mode = MODE_SEL; bus4.sel = 2'd0; bus4.in_valid = 4'b0001;
    bus4.in_data = 32'h0000003C;
    step();
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus4.in_data = $urandom; bus4.in_valid = 4'($urandom); bus4.sel = 2'($urandom);
      bus4.sel_mode = 1'($urandom);
      #1 chk("bp_ready", 32'(bus4.in_ready), 32'd0);
      step();
      chk("bp_data", 32'(bus4.out_data), 32'h3C);
      chk("bp_ch", 32'(bus4.out_ch), 32'd0);
    end
    bus4.out_ready = 1'b1; bus4.sel_mode = MODE_SEL; bus4.sel = 2'd1;
    bus4.in_valid = 4'b0010; bus4.in_data = 32'h00007700;
    step();
    chk("bp_release_data", 32'(bus4.out_data), 32'h77);
    chk("bp_release_valid", 32'(bus4.out_valid), 32'd1);

    // Three channels: wrap and out-of-range select
    bus4.in_valid = 4'h0;
    bus3.sel_mode = MODE_SEL; bus3.sel = 2'd2; bus3.in_valid = 3'h7; bus3.in_data = 24'h330000;
    step();
    chk("ch3_sel2", 32'(bus3.out_ch), 32'd2);
    bus3.sel_mode = MODE_ARB; bus3.in_valid = 3'b101;
    step();
    chk("ch3_wrap", 32'(bus3.out_ch), 32'd0);
    bus3.sel_mode = MODE_SEL; bus3.sel = 2'd3; bus3.in_valid = 3'h7;
    #1 chk("ch3_sel3_ready", 32'(bus3.in_ready), 32'd0);
    step();
    chk("ch3_sel3_valid", 32'(bus3.out_valid), 32'd0);

    // Reset while holding a beat with a transfer pending
    bus3.in_valid = 3'h0;
    bus4.sel_mode = MODE_ARB; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
    step();
    step();
    bus4.out_ready = 1'b0;
    step();
    rst = 1'b1; bus4.out_ready = 1'b1;
    step();
    chk("midrst_valid", 32'(bus4.out_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("midrst_grant", 32'(bus4.out_ch), 32'd0);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus4.in_data = $urandom; bus4.in_valid = 4'($urandom); bus4.sel_mode = 1'($urandom);
      bus4.sel = 2'($urandom); bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus3.in_data = 24'($urandom); bus3.in_valid = 3'($urandom); bus3.sel_mode = 1'($urandom);
      bus3.sel = 2'($urandom); bus3.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
